uart_tx_buffer: RTL and testbench

UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

---
 rtl/uart_tx_buffer.sv | 145 ++++++++++++++
 tb/tb_uart_tx_buffer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffer.sv
// Byte FIFO feeding an 8N1 UART transmitter; define UART_TX_PARITY_EN to insert
// an even-parity bit between the last data bit and the stop bit (8E1 framing).
module uart_tx_buffer #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       SYS_clk,
    input  logic       SYS_reset,
    input  logic       DMEM_transmit_request,
    input  logic [7:0] DMEM_data_transmit,
    output logic       transmitter_buffer_full,
    output logic       uart_tx,
    output logic       tx_busy,
    output logic       overflow
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LOAD  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]    COUNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t             state_reg;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [PTR_W:0]     count_reg;
    logic [BAUD_W-1:0]  baud_reg;
    logic [2:0]         bit_idx_reg;
    logic [7:0]         shift_reg;
    logic               uart_tx_reg;
    logic               overflow_reg;
`ifdef UART_TX_PARITY_EN
    logic               parity_reg;
`endif

    // Asynchronous read: the head byte must be ready on the same edge it is popped.
    logic [7:0] fifo_mem [FIFO_DEPTH];
    logic [7:0] head;
    logic       push;
    logic       pop;

    assign transmitter_buffer_full = (count_reg == COUNT_FULL);
    assign head     = fifo_mem[rd_ptr_reg];
    assign uart_tx  = uart_tx_reg;
    assign overflow = overflow_reg;
    assign tx_busy  = (state_reg != IDLE) || (count_reg != '0);

    always_comb begin
        push = DMEM_transmit_request && !transmitter_buffer_full;
        pop  = (count_reg != '0) &&
               ((state_reg == IDLE) || (state_reg == STOP && baud_reg == '0));
    end

    always_ff @(posedge SYS_clk) begin
        if (!SYS_reset && push)
            fifo_mem[wr_ptr_reg] <= DMEM_data_transmit;
    end

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            state_reg    <= IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            baud_reg     <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
            uart_tx_reg  <= 1'b1;
            overflow_reg <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_reg   <= 1'b0;
`endif
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (PTR_W + 1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W + 1)'(1);
                default: count_reg <= count_reg;
            endcase
            if (DMEM_transmit_request && transmitter_buffer_full)
                overflow_reg <= 1'b1;

            case (state_reg)
                IDLE: uart_tx_reg <= 1'b1;
                START, PARITY: begin
                    if (baud_reg == '0) begin
                        baud_reg    <= BAUD_LOAD;
                        state_reg   <= (state_reg == START) ? DATA : STOP;
                        uart_tx_reg <= (state_reg == START) ? shift_reg[0] : 1'b1;
                    end else begin
                        baud_reg <= baud_reg - BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud_reg == '0) begin
                        baud_reg <= BAUD_LOAD;
                        if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_reg   <= PARITY;
                            uart_tx_reg <= parity_reg;
`else
                            state_reg   <= STOP;
                            uart_tx_reg <= 1'b1;
`endif
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                            shift_reg   <= {1'b0, shift_reg[7:1]};
                            uart_tx_reg <= shift_reg[1];
                        end
                    end else begin
                        baud_reg <= baud_reg - BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (baud_reg == '0) begin
                        state_reg   <= IDLE;
                        uart_tx_reg <= 1'b1;
                    end else begin
                        baud_reg <= baud_reg - BAUD_W'(1);
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    uart_tx_reg <= 1'b1;
                end
            endcase

            // A pop (from IDLE or at the end of STOP) overrides the case above and
            // starts the next frame with no idle gap.
            if (pop) begin
                state_reg   <= START;
                uart_tx_reg <= 1'b0;
                baud_reg    <= BAUD_LOAD;
                bit_idx_reg <= '0;
                shift_reg   <= head;
`ifdef UART_TX_PARITY_EN
                parity_reg  <= ^head;
`endif
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_buffer.sv
// Randomized and directed bench for uart_tx_buffer (CLKS_PER_BIT=4, FIFO_DEPTH=4,
// 10-bit frames) compared cycle by cycle against a frame-timer reference model.
module tb_uart_tx_buffer;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       SYS_clk = 1'b0;
    logic       SYS_reset = 1'b1;
    logic       DMEM_transmit_request = 1'b0;
    logic [7:0] DMEM_data_transmit = 8'h00;
    logic       transmitter_buffer_full;
    logic       uart_tx;
    logic       tx_busy;
    logic       overflow;

    uart_tx_buffer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .SYS_clk                 (SYS_clk),
        .SYS_reset               (SYS_reset),
        .DMEM_transmit_request   (DMEM_transmit_request),
        .DMEM_data_transmit      (DMEM_data_transmit),
        .transmitter_buffer_full (transmitter_buffer_full),
        .uart_tx                 (uart_tx),
        .tx_busy                 (tx_busy),
        .overflow                (overflow)
    );

    always #5 SYS_clk = ~SYS_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: pending-byte queue plus a position t inside the current frame.
    logic [7:0] m_q[$];
    logic       m_active = 1'b0;
    int         m_t = 0;
    logic [7:0] m_cur = 8'h00;
    logic       m_ovf = 1'b0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic line_level(input int t, input logic [7:0] b);
        int k;
        k = t / CPB;
        if (k == 0)
            return 1'b0;
        if (k <= 8)
            return b[k-1];
        return 1'b1;
    endfunction

    task automatic model_edge(input logic rst, input logic req, input logic [7:0] d);
        logic       was_full;
        logic       do_pop;
        logic [7:0] popped;
        if (rst) begin
            m_q.delete();
            m_active = 1'b0;
            m_t      = 0;
            m_ovf    = 1'b0;
            return;
        end
        was_full = (m_q.size() == DEPTH);
        do_pop   = (m_q.size() > 0) && (!m_active || m_t == FRAME - 1);
        popped   = 8'h00;
        if (do_pop)
            popped = m_q.pop_front();
        if (m_active) begin
            if (m_t == FRAME - 1) begin
                $display("frame sent %02h", m_cur);
                if (do_pop) begin
                    m_cur = popped;
                    m_t   = 0;
                end else begin
                    m_active = 1'b0;
                end
            end else begin
                m_t++;
            end
        end else if (do_pop) begin
            m_active = 1'b1;
            m_t      = 0;
            m_cur    = popped;
        end
        if (req) begin
            if (was_full) begin
                m_ovf = 1'b1;
                $display("push %02h dropped (buffer full)", d);
            end else begin
                m_q.push_back(d);
                $display("push %02h accepted", d);
            end
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, compare on the falling edge.
    task automatic step(input logic rst, input logic req, input logic [7:0] d);
        logic exp_tx;
        SYS_reset             = rst;
        DMEM_transmit_request = req;
        DMEM_data_transmit    = d;
        @(posedge SYS_clk);
        model_edge(rst, req, d);
        @(negedge SYS_clk);
        exp_tx = m_active ? line_level(m_t, m_cur) : 1'b1;
        check("uart_tx", {31'd0, uart_tx}, {31'd0, exp_tx});
        check("tx_busy", {31'd0, tx_busy}, {31'd0, (m_active || m_q.size() > 0)});
        check("buffer_full", {31'd0, transmitter_buffer_full}, {31'd0, (m_q.size() == DEPTH)});
        check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 8'h00);

        // Single byte into an idle block
        step(1'b0, 1'b1, 8'hA5);
        idle(45);

        // Four consecutive pushes: contiguous frames, never full
        for (int i = 1; i <= 4; i++)
            step(1'b0, 1'b1, 8'(i));
        idle(170);

        // Six consecutive pushes: fifth fills, sixth dropped, overflow sticky
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b1, 8'(8'h30 + i));
        idle(220);
        step(1'b1, 1'b0, 8'h00);

        // Reset at cycle 15 of an FF frame with two bytes queued
        step(1'b0, 1'b1, 8'hFF);
        step(1'b0, 1'b1, 8'h02);
        step(1'b0, 1'b1, 8'h03);
        idle(12);
        step(1'b1, 1'b1, 8'h77);
        idle(50);

        // Hold the request while full so a push meets the pop edge
        for (int i = 0; i < 90; i++)
            step(1'b0, 1'b1, 8'($urandom_range(0, 255)));
        idle(250);
        step(1'b1, 1'b0, 8'h00);

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 599) == 0), ($urandom_range(0, 9) == 0),
                 8'($urandom_range(0, 255)));
        idle(250);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
